serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder controller. Sequences a single one-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands, LSB first, with a carry register between cycles. Trades WIDTH-1 adder cells for a small FSM, two shift registers and a counter. Intended for area-constrained arithmetic paths that accept multi-cycle latency, fronted by a start/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users)

Ports:
clk     input   1      single clock; all state updates on rising edge
rst     input   1      synchronous reset, active-high
start   input   1      request to begin an operation; sampled only when ready=1
a       input   WIDTH  operand A; captured on accepted start
b       input   WIDTH  operand B; captured on accepted start
c_in    input   1      initial carry; captured on accepted start
ready   output  1      high in IDLE and DONE; start is accepted only when high
busy    output  1      high in RUN
sum     output  WIDTH  result; valid while done=1 and held until next accepted start
c_out   output  1      final carry out; same validity as sum
done    output  1      one-cycle pulse; result valid

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on any edge with rst=1, FSM->IDLE, counter=0, shift regs=0, carry reg=0, sum=0, c_out=0, done=0, busy=0, ready=1. rst has priority over every other input, including mid-RUN; the in-flight operation is discarded and no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. start=1 -> load a_sr<=a, b_sr<=b, carry<=c_in, counter<=0, clear result shift reg; next state RUN. start=0 -> stay.
- RUN: busy=1, ready=0. Each cycle the full-adder cell sees a_sr[0], b_sr[0], carry. Result bit shifts into the result reg at MSB, shifting right. carry<=cell c_out. a_sr, b_sr shift right by 1. counter increments. When counter==WIDTH-1 (last bit), next state DONE and the final carry is captured into c_out. start is ignored in RUN; a/b/c_in changes have no effect.
- DONE: done=1 for exactly this cycle, ready=1. sum and c_out are valid. start=1 -> accepted exactly as in IDLE (back-to-back), next state RUN. Otherwise next state IDLE.
- Latency: start accepted on edge N; RUN occupies edges N+1..N+WIDTH; done is high in the cycle after edge N+WIDTH. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- sum/c_out hold their value through IDLE until the next accepted start. During RUN they are not guaranteed stable; they hold either the previous result or partial bits. The implementation holds the previous result in a separate output register updated on entry to DONE.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1). No overflow flag.
- Exactly one full-adder cell instance. No WIDTH-wide adder may be inferred.

Optional Feature:
SERIAL_ADD_SUB_EN: when defined, adds input port sub (1 bit, captured on accepted start). With sub=1, b is inverted on capture and the initial carry is forced to 1, so the block computes a - b. c_in is ignored and c_out=1 means no borrow. With sub=0 the behaviour is identical to the base block. When the macro is undefined, the sub port does not exist and the block only adds.

Test Plan:
- Reset, then start with a=8'h3C, b=8'h5A, c_in=0 -> busy for 8 cycles; done pulses once, 9 cycles after the start edge; sum=8'h96, c_out=0.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Then a=8'h00, b=8'h00, c_in=1 -> sum=8'h01, c_out=0.
- Start with a=8'h11, b=8'h22, then pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 -> ignored; result sum=8'h33, c_out=0, only one done.
- Back-to-back: start held high through DONE with a=8'h80, b=8'h80 after a first op -> second op accepted in the DONE cycle; second done 9 cycles later; sum=8'h00, c_out=1.
- Assert rst at RUN cycle 4 -> next cycle ready=1, busy=0, sum=0, c_out=0; no done pulse. A new op (8'h01 + 8'h01) afterwards gives sum=8'h02.
- With SERIAL_ADD_SUB_EN: sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, c_out=0. sub=1, a=8'h07, b=8'h05 -> sum=8'h02, c_out=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB-first over WIDTH cycles behind a start/done handshake.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds the `sub` input port).

module serial_add_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("serial_add_ctrl: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a_sr, r_b_sr, r_res, r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry, r_cout;
  logic               w_accept, w_last, w_run;
  logic               w_fa_s, w_fa_c;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_c_load;

  // Subtraction is a + ~b + 1; the inversion happens once at capture time.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : c_in;
`else
  assign w_b_load = b;
  assign w_c_load = c_in;
`endif

  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = ready & start;

  serial_add_fa u_fa (
    .i_a (r_a_sr[0]),
    .i_b (r_b_sr[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_sr  <= a;
        r_b_sr  <= w_b_load;
        r_carry <= w_c_load;
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (w_run) begin
        r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
        r_carry <= w_fa_c;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      // Visible result only changes on entry to DONE, so it holds through the next RUN.
      if (w_run && w_last) begin
        r_sum  <= {w_fa_s, r_res[WIDTH-1:1]};
        r_cout <= w_fa_c;
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); subtract vectors run when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, c_in;
  logic [W-1:0] a, b;
  logic         ready, busy, c_out, done;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .sum(sum), .c_out(c_out), .done(done)
  );

  always #5 clk = ~clk;

  // Present an operation so that it is accepted at the next rising edge.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    @(negedge clk);
    a = ia; b = ib; c_in = ic; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Samples on falling edges after the start edge; lat is the 1-based sample index where done is seen.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({ready, busy, done, c_out, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b co=%b sum=%h, want 1 0 0 0 00",
               ready, busy, done, c_out, sum);
    end
  endtask

  task automatic test_basic_add;
    int lat, bn;
    launch(8'h3C, 8'h5A, 1'b0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9) begin tests_failed++; $display("FAIL basic_latency: got %0d want 9", lat); end
    tests_run++;
    if (bn !== 8) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d want 8", bn); end
    tests_run++;
    if ({c_out, sum} !== {1'b0, 8'h96}) begin
      tests_failed++; $display("FAIL basic_result: got %b_%h want 0_96", c_out, sum);
    end
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL ready_in_done: got %b want 1", ready); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      tests_failed++; $display("FAIL done_single_pulse: got done=%b rdy=%b want 0 1", done, ready);
    end
    tests_run++;
    if ({c_out, sum} !== {1'b0, 8'h96}) begin
      tests_failed++; $display("FAIL result_hold_idle: got %b_%h want 0_96", c_out, sum);
    end
  endtask

  task automatic test_edges;
    int lat, bn;
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9 || {c_out, sum} !== {1'b1, 8'h00}) begin
      tests_failed++; $display("FAIL carry_wrap: got lat=%0d %b_%h want 9 1_00", lat, c_out, sum);
    end
    launch(8'h00, 8'h00, 1'b1);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9 || {c_out, sum} !== {1'b0, 8'h01}) begin
      tests_failed++; $display("FAIL carry_in_only: got lat=%0d %b_%h want 9 0_01", lat, c_out, sum);
    end
  endtask

  task automatic test_start_ignored;
    int ndone, lat;
    ndone = 0; lat = -1;
    launch(8'h11, 8'h22, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          tests_run++;
          if ({c_out, sum} !== {1'b0, 8'h33}) begin
            tests_failed++; $display("FAIL ignore_start_result: got %b_%h want 0_33", c_out, sum);
          end
        end
      end
    end
    tests_run++;
    if (lat !== 9 || ndone !== 1) begin
      tests_failed++; $display("FAIL ignore_start_done: got lat=%0d dones=%0d want 9 1", lat, ndone);
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_start_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    launch(8'h01, 8'h02, 1'b0);
    a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9 || {c_out, sum} !== {1'b0, 8'h03}) begin
      tests_failed++; $display("FAIL b2b_first: got lat=%0d %b_%h want 9 0_03", lat, c_out, sum);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9 || bn !== 8) begin
      tests_failed++; $display("FAIL b2b_timing: got lat=%0d busy=%0d want 9 8", lat, bn);
    end
    tests_run++;
    if ({c_out, sum} !== {1'b1, 8'h00}) begin
      tests_failed++; $display("FAIL b2b_second: got %b_%h want 1_00", c_out, sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat, bn, ndone;
    launch(8'h3C, 8'h5A, 1'b0);
    wait_done(lat, bn);
    launch(8'h10, 8'h20, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({ready, busy, done, c_out, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL midrun_reset: got rdy=%b busy=%b done=%b co=%b sum=%h want 1 0 0 0 00",
               ready, busy, done, c_out, sum);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    tests_run++;
    if (ndone !== 0) begin tests_failed++; $display("FAIL midrun_no_done: got %0d active cycles want 0", ndone); end
    launch(8'h01, 8'h01, 1'b0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9 || {c_out, sum} !== {1'b0, 8'h02}) begin
      tests_failed++; $display("FAIL after_reset_op: got lat=%0d %b_%h want 9 0_02", lat, c_out, sum);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int lat, bn;
    sub = 1'b1;
    launch(8'h05, 8'h07, 1'b0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9 || {c_out, sum} !== {1'b0, 8'hFE}) begin
      tests_failed++; $display("FAIL sub_borrow: got lat=%0d %b_%h want 9 0_FE", lat, c_out, sum);
    end
    launch(8'h07, 8'h05, 1'b0);
    wait_done(lat, bn);
    tests_run++;
    if (lat !== 9 || {c_out, sum} !== {1'b1, 8'h02}) begin
      tests_failed++; $display("FAIL sub_no_borrow: got lat=%0d %b_%h want 9 1_02", lat, c_out, sum);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_basic_add;
    test_edges;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
